result_checker: RTL
===================

Name: result_checker

Overview:
Synthesizable compare engine that replaces the bench-side result comparator and compute timer. It streams N words from a result SRAM and a golden SRAM and counts matching entries, with an optional signed tolerance. It also captures the first mismatching index and measures how many cycles the DUT is busy. It sits beside the accelerator and drives the read ports of both SRAMs, which use the team's standard synchronous-read model.

Parameters:
ADDR_WIDTH, 12, SRAM address width; also width of count and index fields.
DATA_WIDTH, 16, SRAM word width; words are compared as two's complement.
READ_LATENCY, 1, cycles from read address to valid read data (1..4).
TOLERANCE, 0, max allowed |result - golden|; 0 means exact compare.
CYCLE_WIDTH, 32, width of the busy-cycle counter.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a check; ignored while busy=1
num_result  in  ADDR_WIDTH+1  number of words to compare (0..2^ADDR_WIDTH); sampled on start
result_base  in  ADDR_WIDTH  first address in the result SRAM; sampled on start
golden_base  in  ADDR_WIDTH  first address in the golden SRAM; sampled on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when all compares have retired
res_read_address  out  ADDR_WIDTH  result SRAM read address
res_read_data  in  DATA_WIDTH  result SRAM read data
gold_read_address  out  ADDR_WIDTH  golden SRAM read address
gold_read_data  in  DATA_WIDTH  golden SRAM read data
correct_count  out  ADDR_WIDTH+1  number of matching words in the last check
mismatch_seen  out  1  at least one mismatch occurred in the last check
first_mismatch_idx  out  ADDR_WIDTH  index (0-based) of the first mismatch
dut_busy  in  1  busy signal of the monitored DUT
compute_cycles  out  CYCLE_WIDTH  length in cycles of the last dut_busy high period

Behaviour:
- Reset: every output is 0; FSM in IDLE; internal pipeline cleared. An asserted reset aborts any check in progress, and no done pulse is produced for it.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, latch num_result and both bases; clear correct_count, mismatch_seen and first_mismatch_idx.
  - If num_result=0, go to DONE.
  - Otherwise go to ISSUE.
  - busy rises on the next cycle in both cases.
- ISSUE: issue one index per cycle, idx = 0..num_result-1.
  - res_read_address = result_base + idx and gold_read_address = golden_base + idx, each modulo 2^ADDR_WIDTH (wrap-around is legal).
  - After the last index is issued, go to DRAIN.
- Compare pipeline: a valid+idx shift register of depth READ_LATENCY. The compare for idx happens READ_LATENCY cycles after its issue.
  - diff = sign-extended res - gold, computed in DATA_WIDTH+1 bits.
  - A word matches when |diff| <= TOLERANCE.
  - Match: correct_count increments.
  - Mismatch while mismatch_seen=0: capture first_mismatch_idx = idx, set mismatch_seen.
- DRAIN: wait until the pipeline holds no valid entry, then go to DONE.
- DONE: done=1 for exactly one cycle; busy falls in the same cycle; go to IDLE.
- Latency: done is asserted num_result + READ_LATENCY + 1 cycles after the start cycle (num_result>0), and 2 cycles after start when num_result=0.
- While idle, read addresses hold their last value.
- A start arriving in the DONE cycle is ignored.
- Results stay stable until the next accepted start.
- Cycle timer (independent of the FSM):
  - On a rising edge of dut_busy, clear the running counter.
  - Count every cycle while dut_busy=1, saturating at all-ones.
  - On a falling edge, copy the running value to compute_cycles, so compute_cycles equals the number of cycles dut_busy was sampled high.
  - A check and the timer may run concurrently.

Test Plan:
- Golden equals result for 96 words, bases 0x000/0x000, READ_LATENCY=1, start pulsed -> done exactly 98 cycles after start; correct_count=96; mismatch_seen=0.
- Same data with words 5 and 40 corrupted -> correct_count=94; mismatch_seen=1; first_mismatch_idx=5.
- TOLERANCE=2: result 0x7FFE vs golden 0x8000 -> mismatch (large signed diff); result 0xFFFF vs golden 0x0001 -> match.
- result_base=0xFF0, num_result=32 -> addresses wrap 0xFFF to 0x000; all 32 compared; a second start during busy has no effect.
- num_result=0 -> done 2 cycles after start, correct_count=0; then reset asserted mid-check with num_result=144 -> all outputs 0 and no done pulse.
- dut_busy held high for 1234 cycles -> compute_cycles=1234 after the falling edge; a following 7-cycle pulse -> compute_cycles=7.

Source files
------------

// File: rtl/result_checker_if.sv
// Read-port bundle for the result and golden SRAMs driven by result_checker.
// The checker is the master (drives addresses); the SRAM models are the slave.
interface result_checker_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] res_read_address;
  logic [DATA_WIDTH-1:0] res_read_data;
  logic [ADDR_WIDTH-1:0] gold_read_address;
  logic [DATA_WIDTH-1:0] gold_read_data;

  modport master (
    output res_read_address,
    output gold_read_address,
    input  res_read_data,
    input  gold_read_data
  );

  modport slave (
    input  res_read_address,
    input  gold_read_address,
    output res_read_data,
    output gold_read_data
  );
endinterface

// File: rtl/result_checker.sv
// Streams N words from the result and golden SRAMs, counts tolerance matches,
// records the first mismatch, and times the high periods of a monitored busy line.
module result_checker #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int TOLERANCE    = 0,
  parameter int CYCLE_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    num_result,
  input  logic [ADDR_WIDTH-1:0]  result_base,
  input  logic [ADDR_WIDTH-1:0]  golden_base,
  output logic                   busy,
  output logic                   done,
  result_checker_if.master       sram,
  output logic [ADDR_WIDTH:0]    correct_count,
  output logic                   mismatch_seen,
  output logic [ADDR_WIDTH-1:0]  first_mismatch_idx,
  input  logic                   dut_busy,
  output logic [CYCLE_WIDTH-1:0] compute_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [ADDR_WIDTH:0]     r_num;
  logic [ADDR_WIDTH-1:0]   r_issue;
  logic [ADDR_WIDTH-1:0]   r_res_addr;
  logic [ADDR_WIDTH-1:0]   r_gold_addr;
  logic [READ_LATENCY-1:0] r_vld_p;
  logic [ADDR_WIDTH-1:0]   r_idx_p [READ_LATENCY];
  logic [ADDR_WIDTH:0]     r_count;
  logic                    r_seen;
  logic [ADDR_WIDTH-1:0]   r_first;
  logic                    r_dut_busy_d;
  logic [CYCLE_WIDTH-1:0]  r_run;
  logic [CYCLE_WIDTH-1:0]  r_cycles;

  logic w_last;
  logic w_drain_ok;
  logic w_match;

  // Difference is formed one bit wider so opposite-sign extremes cannot wrap.
  function automatic logic f_match(input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH:0] d;
    logic        [DATA_WIDTH:0] mag;
    d   = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    mag = d[DATA_WIDTH] ? unsigned'(-d) : unsigned'(d);
    return 64'(mag) <= 64'(TOLERANCE);
  endfunction

  function automatic logic [CYCLE_WIDTH-1:0] f_sat_inc(input logic [CYCLE_WIDTH-1:0] v);
    return (&v) ? v : v + CYCLE_WIDTH'(1);
  endfunction

  assign w_last  = ({1'b0, r_issue} + (ADDR_WIDTH+1)'(1)) == r_num;
  assign w_match = f_match(sram.res_read_data, sram.gold_read_data);

  // Leaving DRAIN is allowed once only the entry retiring on this edge is left.
  always_comb begin
    w_drain_ok = 1'b1;
    for (int j = 0; j < READ_LATENCY-1; j++) begin
      if (r_vld_p[j]) w_drain_ok = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_num       <= '0;
      r_issue     <= '0;
      r_res_addr  <= '0;
      r_gold_addr <= '0;
      r_vld_p     <= '0;
      for (int j = 0; j < READ_LATENCY; j++) r_idx_p[j] <= '0;
      r_count     <= '0;
      r_seen      <= 1'b0;
      r_first     <= '0;
    end else begin
      // stage p0..pN: index travels alongside its outstanding SRAM read
      r_vld_p[0] <= 1'b0;
      for (int j = READ_LATENCY-1; j > 0; j--) begin
        r_vld_p[j] <= r_vld_p[j-1];
        r_idx_p[j] <= r_idx_p[j-1];
      end

      // compare stage: read data for the oldest entry is valid now
      if (r_vld_p[READ_LATENCY-1]) begin
        if (w_match) begin
          r_count <= r_count + (ADDR_WIDTH+1)'(1);
        end else if (!r_seen) begin
          r_seen  <= 1'b1;
          r_first <= r_idx_p[READ_LATENCY-1];
        end
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_num       <= num_result;
            r_issue     <= '0;
            r_res_addr  <= result_base;
            r_gold_addr <= golden_base;
            r_count     <= '0;
            r_seen      <= 1'b0;
            r_first     <= '0;
            r_busy      <= 1'b1;
            // An empty check still passes through DRAIN so done lands two cycles out.
            r_state     <= (num_result == '0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_vld_p[0] <= 1'b1;
          r_idx_p[0] <= r_issue;
          if (w_last) begin
            r_state <= S_DRAIN;
          end else begin
            r_issue     <= r_issue + ADDR_WIDTH'(1);
            r_res_addr  <= r_res_addr + ADDR_WIDTH'(1);
            r_gold_addr <= r_gold_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_ok) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Timer: restart on the rising edge, publish on the falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dut_busy_d <= 1'b0;
      r_run        <= '0;
      r_cycles     <= '0;
    end else begin
      r_dut_busy_d <= dut_busy;
      if (dut_busy && !r_dut_busy_d) begin
        r_run <= CYCLE_WIDTH'(1);
      end else if (dut_busy) begin
        r_run <= f_sat_inc(r_run);
      end
      if (!dut_busy && r_dut_busy_d) begin
        r_cycles <= r_run;
      end
    end
  end

  assign busy                   = r_busy;
  assign done                   = r_done;
  assign sram.res_read_address  = r_res_addr;
  assign sram.gold_read_address = r_gold_addr;
  assign correct_count          = r_count;
  assign mismatch_seen          = r_seen;
  assign first_mismatch_idx     = r_first;
  assign compute_cycles         = r_cycles;

endmodule
